// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty sequencer and its period counter.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRamp,
    StStop
  } ramp_state_e;

  // One saturating step from duty toward tgt; never overshoots and never wraps.
  // Computed in 32 bits, which covers the WIDTH+1 headroom for any WIDTH up to 31.
  function automatic int unsigned sat_step(input int unsigned duty,
                                           input int unsigned tgt,
                                           input int unsigned step);
    int unsigned res;
    if (tgt > duty) begin
      res = duty + step;
      if (res > tgt) res = tgt;
    end else if (step > duty - tgt) begin
      res = tgt;
    end else begin
      res = duty - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter; flags the first and last count of each period.
module pwm_period_counter #(
  parameter int unsigned Width = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic period_start_o,
  output logic boundary_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign period_start_o = (cnt_q == '0);
  assign boundary_o     = &cnt_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer: ramps the PWM duty toward an accepted target, one step per N periods,
// with every change landing on a period boundary. Dropping en ramps the duty down to 0.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] periods_per_step,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             period_start,
  output logic             busy,
  output logic             done
);

  ramp_state_e      state_q, state_d;
  logic [WIDTH-1:0] sc_q, sc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             done_q, done_d;

  logic             boundary;
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH-1:0] pps_eff;
  logic             step_due;
  logic [WIDTH-1:0] stepped;
  logic             accept;

  pwm_period_counter #(
    .Width(WIDTH)
  ) u_period_counter (
    .clk_i         (clkin),
    .rst_ni        (reset),
    .period_start_o(period_start),
    .boundary_o    (boundary)
  );

  assign step_eff = (step == '0) ? WIDTH'(1) : step;
  assign pps_eff  = (periods_per_step == '0) ? WIDTH'(1) : periods_per_step;
  assign step_due = boundary &&
                    (((WIDTH+1)'(sc_q) + (WIDTH+1)'(1)) >= (WIDTH+1)'(pps_eff));
  assign stepped  = WIDTH'(sat_step(32'(duty_q), 32'(tgt_q), 32'(step_eff)));

  // Ready is masked by reset so it reads 0 while reset is held.
  assign target_ready = reset && en && (state_q == StIdle);
  assign accept       = target_valid && target_ready;
  assign busy         = (state_q != StIdle);
  assign duty_cycle   = duty_q;
  assign done         = done_q;

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    tgt_d   = tgt_q;
    duty_d  = duty_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tgt_d = target;
          sc_d  = '0;
          if (target == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = StRamp;
          end
        end else if (!en && (duty_q != '0)) begin
          state_d = StStop;
          tgt_d   = '0;
          sc_d    = '0;
        end
      end

      StRamp, StStop: begin
        // A soft-stop request takes priority over a step on the same edge.
        if ((state_q == StRamp) && !en) begin
          state_d = StStop;
          tgt_d   = '0;
          sc_d    = '0;
        end else if (step_due) begin
          duty_d = stepped;
          sc_d   = '0;
          if (stepped == tgt_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else if (boundary) begin
          sc_d = sc_q + WIDTH'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!reset) begin
      state_q <= StIdle;
      sc_q    <= '0;
      tgt_q   <= '0;
      duty_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios plus randomized traffic, every cycle compared
// against a behavioural reference model.
module tb_pwm_ramp_ctrl;

  localparam int Max = 255;

  typedef enum int {MIdle, MRamp, MStop} mode_e;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] target;
  logic       tv;
  logic       target_ready;
  logic [7:0] step;
  logic [7:0] pps;
  logic [7:0] duty_cycle;
  logic       period_start;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .WIDTH(8)
  ) dut (
    .clkin           (clk),
    .reset           (rst_n),
    .en              (en),
    .target          (target),
    .target_valid    (tv),
    .target_ready    (target_ready),
    .step            (step),
    .periods_per_step(pps),
    .duty_cycle      (duty_cycle),
    .period_start    (period_start),
    .busy            (busy),
    .done            (done)
  );

  // Reference model state
  int    m_cnt, m_sc, m_tgt, m_duty;
  mode_e m_mode;
  bit    m_done;

  int n_checks = 0;
  int n_fail   = 0;
  int seen[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_apply_step();
    int s;
    if (m_sc + 1 >= eff(int'(pps))) begin
      s = eff(int'(step));
      if (m_tgt > m_duty) m_duty = (m_duty + s > m_tgt) ? m_tgt : m_duty + s;
      else                m_duty = (m_duty - s < m_tgt) ? m_tgt : m_duty - s;
      m_sc = 0;
      if (m_duty == m_tgt) begin
        m_mode = MIdle;
        m_done = 1'b1;
      end
    end else begin
      m_sc++;
    end
  endtask

  task automatic model_step();
    bit bnd;
    if (!rst_n) begin
      m_cnt = 0; m_sc = 0; m_tgt = 0; m_duty = 0; m_mode = MIdle; m_done = 1'b0;
      return;
    end
    bnd    = (m_cnt == Max);
    m_done = 1'b0;
    case (m_mode)
      MIdle: begin
        if (tv && en) begin
          m_tgt = int'(target);
          m_sc  = 0;
          if (m_tgt == m_duty) m_done = 1'b1;
          else                 m_mode = MRamp;
        end else if (!en && m_duty != 0) begin
          m_mode = MStop; m_tgt = 0; m_sc = 0;
        end
      end
      MRamp: begin
        if (!en) begin
          m_mode = MStop; m_tgt = 0; m_sc = 0;
        end else if (bnd) begin
          model_apply_step();
        end
      end
      default: if (bnd) model_apply_step();
    endcase
    m_cnt = (m_cnt + 1) % (Max + 1);
  endtask

  task automatic check_outputs();
    chk("duty", int'(duty_cycle), m_duty);
    chk("period_start", int'(period_start), int'(m_cnt == 0));
    chk("busy", int'(busy), int'(m_mode != MIdle));
    chk("done", int'(done), int'(m_done));
    chk("ready", int'(target_ready), int'(rst_n && en && m_mode == MIdle));
  endtask

  task automatic cycle();
    int prev;
    prev = int'(duty_cycle);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    if (int'(duty_cycle) != prev) seen.push_back(int'(duty_cycle));
  endtask

  task automatic send(input int t, input int s, input int p);
    target = 8'(t);
    step   = 8'(s);
    pps    = 8'(p);
    tv     = 1'b1;
    cycle();
    tv     = 1'b0;
  endtask

  task automatic settle(input int limit);
    for (int i = 0; i < limit && (busy || m_mode != MIdle); i++) cycle();
    chk("settle_busy", int'(busy), 0);
  endtask

  task automatic wait_duty(input int val, input int limit);
    for (int i = 0; i < limit && int'(duty_cycle) != val; i++) cycle();
    chk("wait_duty", int'(duty_cycle), val);
  endtask

  task automatic chk_seen(input string tag, input int e0, input int e1, input int e2,
                          input int e3, input int n);
    int exp[4];
    exp = '{e0, e1, e2, e3};
    chk({tag, "_count"}, seen.size(), n);
    for (int i = 0; i < n && i < seen.size(); i++) chk({tag, "_val"}, seen[i], exp[i]);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; tv = 1'b0; target = '0; step = 8'd1; pps = 8'd1;
    repeat (3) cycle();
    chk("rst_duty", int'(duty_cycle), 0);
    chk("rst_pstart", int'(period_start), 1);
    chk("rst_ready", int'(target_ready), 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Idle with no target
    repeat (600) cycle();
    chk("idle_duty", int'(duty_cycle), 0);

    // 0 -> 64, step 16, every period
    seen.delete();
    send(64, 16, 1);
    chk("accept_busy", int'(busy), 1);
    settle(3000);
    chk_seen("up64", 16, 32, 48, 64, 4);

    // 64 -> 192, then down to 10 with step 50 every 2 periods
    send(192, 64, 1);
    settle(3000);
    chk("at192", int'(duty_cycle), 192);
    seen.delete();
    send(10, 50, 2);
    settle(5000);
    chk_seen("down10", 142, 92, 42, 10, 4);

    // Step 0 / periods 0 treated as 1
    seen.delete();
    send(12, 0, 0);
    settle(2000);
    chk_seen("zero_step", 11, 12, 0, 0, 2);

    // Target equal to current duty
    send(64, 64, 1);
    settle(2000);
    send(64, 64, 1);
    chk("eq_done", int'(done), 1);
    chk("eq_busy", int'(busy), 0);
    chk("eq_duty", int'(duty_cycle), 64);

    // Soft-stop mid-ramp at 128
    send(255, 64, 1);
    wait_duty(128, 2000);
    en = 1'b0;
    cycle();
    chk("stop_busy", int'(busy), 1);
    seen.delete();
    tv = 1'b1; target = 8'd200;
    repeat (4) cycle();
    tv = 1'b0;
    settle(3000);
    chk_seen("stop", 64, 0, 0, 0, 2);
    repeat (3) cycle();
    chk("stop_ready_low", int'(target_ready), 0);
    en = 1'b1;
    cycle();
    chk("stop_ready_high", int'(target_ready), 1);

    // Reset mid-ramp at 200, then re-ramp from 0
    send(250, 100, 1);
    wait_duty(200, 2000);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_duty", int'(duty_cycle), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_pstart", int'(period_start), 1);
    rst_n = 1'b1;
    seen.delete();
    send(64, 16, 1);
    settle(3000);
    chk_seen("rerun", 16, 32, 48, 64, 4);

    // Randomized traffic: targets, en drops, stray valids, step changes mid-ramp
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 300)) cycle();
      send($urandom_range(0, 255), $urandom_range(32, 128), $urandom_range(0, 2));
      for (int i = 0; i < 20000 && (busy || m_mode != MIdle); i++) begin
        if (en && $urandom_range(0, 399) == 0) en = 1'b0;
        else if (!en && $urandom_range(0, 299) == 0) en = 1'b1;
        tv = ($urandom_range(0, 15) == 0);
        target = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 499) == 0) step = 8'($urandom_range(32, 128));
        cycle();
      end
      tv = 1'b0;
      en = 1'b1;
      chk("rand_settle", int'(busy), 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Duty-cycle sequencer that sits in front of the `PWM` block and drives its `duty_cycle` input. It accepts a target duty through a valid/ready handshake and ramps the PWM duty toward it at a programmable step size and rate. Every duty change lands on a PWM period boundary, so the output never glitches mid-period. Deasserting enable soft-stops the output by ramping duty down to 0.

## Interface
- `WIDTH`, 8: duty and period-counter width. The PWM period is 2^WIDTH clocks.
- `clkin` input 1: system clock, the same clock as `PWM`.
- `reset` input 1: synchronous, active-low.
- `en` input 1: run enable. Low requests a soft-stop.
- `target` input WIDTH: requested duty.
- `target_valid` input 1: `target` is valid.
- `target_ready` output 1: a target can be accepted. Equals `en` && state==IDLE.
- `step` input WIDTH: duty increment per ramp step. 0 is treated as 1.
- `periods_per_step` input WIDTH: PWM periods between steps. 0 is treated as 1.
- `duty_cycle` output WIDTH: registered, connects to `PWM.duty_cycle`.
- `period_start` output 1: high in the cycle where the period counter equals 0.
- `busy` output 1: state is RAMP or STOP.
- `done` output 1: one-cycle pulse when a ramp or a soft-stop completes.

## Operation
- Period counter `cnt`:
  - free-running over 0 .. 2^WIDTH-1, wraps to 0;
  - its reset must coincide with the PWM counter reset (the top level ties the two);
  - `period_start` = (`cnt`==0).
- Boundary event: `cnt`==max. `duty_cycle` may change only on the clock edge at a boundary event.
- Step counter `sc`:
  - counts boundary events;
  - when `sc`+1 reaches the effective `periods_per_step`, a step is applied and `sc` returns to 0;
  - `sc` is cleared on target accept and on entry to STOP.
- Step arithmetic is done in WIDTH+1 bits:
  - up: duty = min(duty+step, tgt);
  - down: duty = max(duty-step, tgt), computed as tgt if step > duty-tgt.
  - No overshoot and no wrap-around.
- States:
  - IDLE: duty is held.
    - On accept (`target_valid` && `target_ready`): latch `tgt`. If `tgt`==duty, pulse `done` next cycle and stay IDLE; otherwise go to RAMP.
    - If `en`=0 and duty≠0: go to STOP.
  - RAMP: apply steps at the step boundaries. When duty==tgt after a step, pulse `done` and return to IDLE.
  - STOP: tgt is forced to 0 and the same step and rate apply. When duty reaches 0, pulse `done` and go to IDLE.
- `en` falling in RAMP goes to STOP on the next edge. STOP ignores `en` rising until it completes.
- `target_valid` while `target_ready`=0 is ignored; no target is queued.
- Inputs `step` and `periods_per_step` are sampled at each step application, so changes take effect on the next step.
- `step` and `periods_per_step` both apply to the RAMP and STOP states.

## Timing
- Reset values (held while `reset`=0):
  - `cnt`=0, `sc`=0, state IDLE, `duty_cycle`=0;
  - `done`=0, `busy`=0, `target_ready`=0;
  - `period_start`=1, because `cnt`=0.
- After reset release, `cnt` counts from 0, and the first boundary event comes 2^WIDTH-1 cycles later.
- Accept at cycle t: state is RAMP at t+1, with `busy`=1 and `target_ready`=0.
- First duty change: at the `periods_per_step`-th boundary event after accept. The new value is visible in the cycle where `period_start`=1.
- `done` is asserted in the same cycle that the final duty value first appears, and state reads IDLE in that cycle.
- `target_ready` returns high in that same cycle if `en`=1.
- Reset asserted mid-ramp: everything returns to reset values on the next edge, and `duty_cycle` drops to 0 immediately (no ramp).

## Structure
- Shared package `pwm_pkg`:
  - state enum `IDLE`/`RAMP`/`STOP`;
  - `PWM_WIDTH`=8 constant;
  - saturating step helper function.
- Sub-module `pwm_period_counter`: WIDTH-bit wrap counter with `period_start` and boundary-event outputs. It is reused by `PWM` in later integration.
- `pwm_ramp_ctrl` holds the FSM, `sc`, the latched `tgt` and the duty register.

## Test plan
- Reset, then `en`=1 with no target: `duty_cycle`=0, `target_ready`=1, `period_start` every 256 cycles, `done` never asserted.
- Target 64, step 16, periods_per_step 1: duty goes 16, 32, 48, 64 at four consecutive period starts. `done` pulses with 64; `busy` falls in the same cycle.
- Ramp 64→192, then target 10 with step 50, periods_per_step 2: duty goes 142, 92, 42, 10 every 512 cycles. No wrap, and clamping to 10 is checked.
- Target equal to current duty (64→64): `done` pulses the cycle after accept, `busy` stays 0, and `duty_cycle` does not change.
- `en` dropped mid-ramp at duty 128 with step 64: state is STOP next cycle and `target_valid` is ignored. Duty goes 64, then 0, then `done` pulses. `target_ready` stays 0 until `en`=1.
- `reset` asserted at duty 200 mid-ramp: `duty_cycle`=0 and state IDLE on the next edge. Re-ramp from 0 behaves exactly as after the first reset.
